// File: rtl/mem_responder_pkg.sv
// Shared types and geometry helpers for the memory responder and its line RAM.
// Struct widths follow the cache controller's default 32-bit address / 128-bit line.
package mem_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_op_e;

    // Byte-offset bits within one line.
    function automatic int ofs_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        mem_op_e                 rw;
        logic [ADDR_W_DEF-1:0]   addr;
        logic [LINE_W_DEF-1:0]   data;
    } mem_req_t;

    typedef struct packed {
        mem_op_e                 rw;
        logic [LINE_W_DEF-1:0]   data;
    } mem_resp_t;
endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory line port: request and response channels, each valid/ready.
// master = cache controller side, slave = memory responder side.
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic              mem_resp_rw;
    logic [LINE_W-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rw, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rw, mem_resp_data
    );
endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous line RAM (DEPTH x LINE_W); read data registered, 1-cycle latency.
// No backpressure; store contents are not reset, only the read register is.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int LINE_W = 128,
    localparam int AW    = idx_bits(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);
    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Line-granular memory responder: one outstanding request, response LATENCY cycles after accept
// (LATENCY..LATENCY+7 with MEM_RESPONDER_JITTER_EN); response held until mem_resp_ready.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int LAT   = (LATENCY < 1) ? 1 : LATENCY;
    localparam int OFS   = ofs_bits(LINE_W);
    localparam int IW    = idx_bits(DEPTH);
    localparam int CNT_W = $clog2(LAT + 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_load;
    logic             req_rdy_q, req_rdy_d;
    logic             resp_vld_q, resp_vld_d;
    mem_op_e          rw_q, rw_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic             accept, rd_fire, ram_we, ram_en;
    logic [IW-1:0]    req_idx, ram_addr;
    logic [LINE_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] unused_addr;

    assign unused_addr = bus.mem_req_addr;
    assign req_idx     = bus.mem_req_addr[OFS +: IW];
    assign accept      = (state_q == S_IDLE) && req_rdy_q && bus.mem_req_valid;
    assign rd_fire     = (state_q == S_WAIT) && (cnt_q == '0) && (rw_q == MEM_RD);
    // Writes commit on the accept edge so a following read always sees them.
    assign ram_we      = accept && bus.mem_req_rw;
    assign ram_en      = ram_we || rd_fire;
    assign ram_addr    = (state_q == S_IDLE) ? req_idx : idx_q;

`ifdef MEM_RESPONDER_JITTER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign cnt_load = CNT_W'(LAT - 1) + CNT_W'(lfsr_q[2:0]);
`else
    assign cnt_load = CNT_W'(LAT - 1);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_rdy_d  = req_rdy_q;
        resp_vld_d = resp_vld_q;
        rw_d       = rw_q;
        idx_d      = idx_q;
        case (state_q)
            S_IDLE: begin
                req_rdy_d = 1'b1;
                if (accept) begin
                    rw_d      = mem_op_e'(bus.mem_req_rw);
                    idx_d     = req_idx;
                    cnt_d     = cnt_load;
                    req_rdy_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    resp_vld_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.mem_resp_ready) begin
                    resp_vld_d = 1'b0;
                    req_rdy_d  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_rdy_q  <= 1'b0;
            resp_vld_q <= 1'b0;
            rw_q       <= MEM_RD;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_rdy_q  <= req_rdy_d;
            resp_vld_q <= resp_vld_d;
            rw_q       <= rw_d;
            idx_q      <= idx_d;
        end
    end

    mem_array #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (bus.mem_req_data),
        .rdata_o (ram_rdata)
    );

    assign bus.mem_req_ready  = req_rdy_q;
    assign bus.mem_resp_valid = resp_vld_q;
    assign bus.mem_resp_rw    = rw_q;
    assign bus.mem_resp_data  = (rw_q == MEM_WR) ? '0 : ram_rdata;

    always @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(bus.mem_req_valid));
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, multi-cycle corner sequences, random traffic vs a line-array model.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;
    localparam int LW    = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(32), .LINE_W(LW)) bus ();

    mem_responder #(
        .ADDR_W  (32),
        .LINE_W  (LW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [LW-1:0] model [DEPTH];
    logic [31:0]   lat_seen = 0;

    typedef struct {
        logic          rw;
        logic [31:0]   addr;
        logic [LW-1:0] data;
        int            bp;
        logic [LW-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr / 32'd16) % DEPTH);
    endfunction

    // Called and returns at a negedge; intrude drives a stray write while the response is held.
    task automatic txn(input logic rw, input logic [31:0] addr, input logic [LW-1:0] wd,
                       input int bp, input bit intrude,
                       output logic rrw, output logic [LW-1:0] rd);
        int   w;
        int   lat;
        logic stable;
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_rw     = rw;
        bus.mem_req_addr   = addr;
        bus.mem_req_data   = wd;
        bus.mem_resp_ready = (bp == 0);
        w = 0;
        while (!bus.mem_req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_seen", bus.mem_req_ready, 1);
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        lat = 0;
        while (!bus.mem_resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
`ifdef MEM_RESPONDER_JITTER_EN
        chk("latency_in_range", (lat >= LAT && lat <= LAT + 7), 1);
`else
        chk("latency", lat, LAT);
`endif
        if (lat < 32) lat_seen[lat] = 1'b1;
        rrw = bus.mem_resp_rw;
        rd  = bus.mem_resp_data;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            if (intrude) begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_rw    = 1'b1;
                bus.mem_req_data  = ~rd;
            end
            @(negedge clk);
            if (bus.mem_resp_valid !== 1'b1 || bus.mem_resp_rw !== rrw ||
                bus.mem_resp_data !== rd || bus.mem_req_ready !== 1'b0) stable = 1'b0;
        end
        if (bp > 0) chk("resp_held_stable", stable, 1);
        bus.mem_req_valid  = 1'b0;
        bus.mem_resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_valid_dropped", bus.mem_resp_valid, 0);
        chk("req_ready_after_resp", bus.mem_req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        vec_t          tbl[7];
        logic          rrw;
        logic [LW-1:0] rd, exp, wd;
        logic [LW-1:0] L5, DB, AL, WR;
        logic [31:0]   a;
        logic          rw;
        int            idx, nbits, sawv;

        L5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        DB = {4{32'hDEAD_BEEF}};
        AL = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        WR = 128'h7777_0000_1111_2222_3333_4444_5555_6666;

        bus.mem_req_valid  = 1'b0;
        bus.mem_req_rw     = 1'b0;
        bus.mem_req_addr   = '0;
        bus.mem_req_data   = '0;
        bus.mem_resp_ready = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            model[i] = {$urandom, $urandom, $urandom, $urandom};
            dut.u_array.mem[i] = model[i];
        end
        model[5] = L5;
        dut.u_array.mem[5] = L5;

        tbl[0] = '{rw: 1'b0, addr: 32'h0000_0050, data: '0, bp: 0,  exp: L5};
        tbl[1] = '{rw: 1'b1, addr: 32'h0000_0200, data: DB, bp: 0,  exp: '0};
        tbl[2] = '{rw: 1'b0, addr: 32'h0000_0200, data: '0, bp: 0,  exp: DB};
        tbl[3] = '{rw: 1'b1, addr: 32'h0000_0010, data: AL, bp: 0,  exp: '0};
        tbl[4] = '{rw: 1'b0, addr: 32'h0000_4010, data: '0, bp: 0,  exp: AL};
        tbl[5] = '{rw: 1'b0, addr: 32'h0010_0058, data: '0, bp: 0,  exp: L5};
        tbl[6] = '{rw: 1'b0, addr: 32'h0000_0050, data: '0, bp: 10, exp: L5};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.mem_req_ready, 0);
        chk("rst_resp_valid", bus.mem_resp_valid, 0);
        chk("rst_resp_rw", bus.mem_resp_rw, 0);
        chk("rst_resp_data", bus.mem_resp_data, 0);
        rst_n = 1'b1;
        chk("req_ready_before_edge", bus.mem_req_ready, 0);
        @(negedge clk);
        chk("req_ready_first_edge", bus.mem_req_ready, 1);

        for (int i = 0; i < 7; i++) begin
            txn(tbl[i].rw, tbl[i].addr, tbl[i].data, tbl[i].bp, (i == 6), rrw, rd);
            chk($sformatf("tbl%0d_rw", i), rrw, tbl[i].rw);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
            if (tbl[i].rw) model[line_of(tbl[i].addr)] = tbl[i].data;
        end
        // The stray write presented during backpressure must not have landed.
        txn(1'b0, 32'h0000_0050, '0, 0, 1'b0, rrw, rd);
        chk("intruder_rejected", rd, L5);

        // Reset two cycles into a read's WAIT
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 32'h50;
        bus.mem_resp_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_req_ready_low", bus.mem_req_ready, 0);
        sawv = 0;
        @(negedge clk);
        chk("abort_req_ready_high", bus.mem_req_ready, 1);
        for (int i = 0; i < LAT + 4; i++) begin
            if (bus.mem_resp_valid) sawv++;
            @(negedge clk);
        end
        chk("abort_no_resp", sawv, 0);
        txn(1'b0, 32'h50, '0, 0, 1'b0, rrw, rd);
        chk("abort_next_read", rd, L5);

        // Reset right after a write is accepted: write stays committed
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b1;
        bus.mem_req_addr  = 32'h300;
        bus.mem_req_data  = WR;
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model[line_of(32'h300)] = WR;
        txn(1'b0, 32'h300, '0, 0, 1'b0, rrw, rd);
        chk("abort_write_kept", rd, WR);

        // Random traffic against the line model
        lat_seen = 0;
        for (int n = 0; n < 100; n++) begin
            rw  = ($urandom_range(0, 9) < 3);
            a   = $urandom;
            wd  = {$urandom, $urandom, $urandom, $urandom};
            idx = line_of(a);
            exp = rw ? '0 : model[idx];
            txn(rw, a, wd, $urandom_range(0, 3), 1'b0, rrw, rd);
            chk("rand_rw", rrw, rw);
            chk("rand_data", rd, exp);
            if (rw) model[idx] = wd;
        end
        nbits = $countones(lat_seen);
`ifdef MEM_RESPONDER_JITTER_EN
        chk("jitter_distinct_latencies", (nbits >= 2), 1);
`else
        chk("fixed_single_latency", nbits, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory end of the cache controller's memory port.
- Accepts line-granular read (refill) and write (writeback) requests from one cache_controller instance (icache or dcache), and holds a behavioural line-wide backing store.
- Returns responses after a fixed, programmable latency over a valid/ready handshake.
- One instance per cache in top-level simulation; also the stand-in for a future DRAM controller.

Parameters:
- ADDR_W, 32, byte-address width of requests.
- LINE_W, 128, cache line width in bits; power of two, at least 32.
- DEPTH, 1024, number of lines in the backing store; power of two.
- LATENCY, 4, cycles from request accept to response valid; minimum 1, and values below 1 are treated as 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mem_req_valid  in  1  request present.
- mem_req_ready  out  1  responder can accept a request.
- mem_req_rw  in  1  0 = read line, 1 = write line.
- mem_req_addr  in  ADDR_W  byte address; low log2(LINE_W/8) bits ignored.
- mem_req_data  in  LINE_W  write line data.
- mem_resp_valid  out  1  response present.
- mem_resp_ready  in  1  cache accepts response.
- mem_resp_rw  out  1  echo of the request's rw.
- mem_resp_data  out  LINE_W  read data; zero for write acks.

Behaviour:
- Line index = mem_req_addr[OFS +: log2(DEPTH)], where OFS = log2(LINE_W/8). Upper address bits are ignored, so the store aliases (wraps) modulo DEPTH lines.
- Reset values: mem_req_ready=0, mem_resp_valid=0, mem_resp_rw=0, mem_resp_data=0, state=IDLE, counter=0.
- Backing store contents are not reset; the bench preloads them via hierarchical access or $readmemh.
- mem_req_ready rises on the first clock edge after reset deasserts.
- Single outstanding request; no pipelining.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: mem_req_ready=1. On mem_req_valid&&mem_req_ready, latch rw, index and data, then:
    - Writes commit to the store on this accept edge.
    - Counter loads LATENCY-1; state goes to WAIT.
    - mem_req_ready drops to 0 for the next cycle.
  - WAIT: counter decrements each cycle. At counter==0:
    - Read data is registered from the store into mem_resp_data.
    - mem_resp_valid is set; state goes to RESP.
    - Net latency: accept edge to valid = LATENCY cycles.
  - RESP: mem_resp_valid, mem_resp_rw and mem_resp_data are held stable until mem_resp_ready.
    - On the handshake edge: mem_resp_valid=0, state goes to IDLE, mem_req_ready=1 next cycle.
    - Minimum request-to-request spacing is LATENCY+2 cycles.
- Write data is visible to any later read, including a read to the same line accepted immediately after the write response.
- Inputs mem_req_* are ignored outside IDLE. The requester must hold them stable until the handshake.
- If mem_resp_ready is already high when valid rises, the handshake completes that same cycle.
- Reset asserted mid-operation: the FSM aborts to IDLE and no response is emitted.
  - A write already accepted remains committed.
  - A read in flight is dropped.
- X on mem_req_valid outside reset triggers an assertion (simulation only).

Optional Feature:
- Macro: MEM_RESPONDER_JITTER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every clock.
  - On request accept, the counter loads LATENCY-1 + lfsr[2:0], giving latency from LATENCY to LATENCY+7.
  - Per-cycle behaviour and the handshake are otherwise unchanged.
  - The LFSR value is exposed only as an internal signal for the bench.
- When undefined: latency is exactly LATENCY; no LFSR logic exists.

Decomposition:
- Shared package mem_pkg:
  - typedef mem_op_e {MEM_RD, MEM_WR}.
  - Localparam functions for OFS and index width.
  - Struct mem_req_t {rw, addr, data} and mem_resp_t {rw, data}, parameterised via package-level defaults matching the cache_controller line width.
- One natural sub-module: mem_array, a single-port synchronous line RAM (DEPTH x LINE_W) with write-enable. It is reusable as the cache data array.
- FSM and counter stay in mem_responder.

Test Plan:
- Preload line 5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; read addr 32'h50, LATENCY=4, resp_ready=1 -> resp_valid exactly 4 cycles after accept, data matches, rw=0.
- Write addr 32'h200 with 128'hDEAD_BEEF repeated, then back-to-back read of 32'h200 -> write ack (rw=1, data=0), then read returns DEAD_BEEF pattern.
- Aliasing, DEPTH=1024, LINE_W=128: write 32'h0000_0010, read 32'h0000_4010 -> same data returned.
- Backpressure: hold resp_ready=0 for 10 cycles after valid -> valid, rw and data stable all 10 cycles; req_ready stays 0; a request presented meanwhile is not accepted.
- Reset asserted 2 cycles into a read's WAIT -> after release: no resp_valid, req_ready=1 one cycle later, next read behaves normally.
- With MEM_RESPONDER_JITTER_EN: 100 random reads -> every latency lies within [LATENCY, LATENCY+7], all data correct, and at least two distinct latencies are observed.
